// File: rtl/hynoc_egress_pktarb.sv
// hynoc egress stage: packet-atomic round-robin arbiter driving the downstream port FIFO write side.
// Optional flit/packet statistics counters are built when HYNOC_EGRESS_STATS_EN is defined.
module hynoc_egress_pktarb #(
  parameter int NB_INPUTS       = 4,
  parameter int LOG2_INPUTS     = $clog2(NB_INPUTS),
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
  parameter int AFULL_MARGIN    = 5,
  parameter int MUX_INPUT_WIDTH = NB_INPUTS * FLIT_WIDTH
) (
  input  logic                       router_clk,
  input  logic                       router_srst,
  output logic                       wclk,
  output logic                       wsrst,
  output logic                       wen,
  output logic [FLIT_WIDTH-1:0]      wdata,
  input  logic [LOG2_FIFO_DEPTH:0]   wlevel,
  input  logic [NB_INPUTS-1:0]       from_ingress_request,
  input  logic [NB_INPUTS-1:0]       from_ingress_write,
  input  logic [MUX_INPUT_WIDTH-1:0] from_ingress_data,
  output logic [NB_INPUTS-1:0]       to_ingress_grant,
  output logic [NB_INPUTS-1:0]       to_ingress_afull
`ifdef HYNOC_EGRESS_STATS_EN
  ,
  output logic [31:0]                stat_flits,
  output logic [15:0]                stat_packets
`endif
);

  generate
    if (FLIT_WIDTH < PAYLOAD_WIDTH + 1) begin : g_bad_flit_width
      $fatal(1, "hynoc_egress_pktarb: FLIT_WIDTH too small for payload plus stop bit");
    end
    if (MUX_INPUT_WIDTH != NB_INPUTS * FLIT_WIDTH) begin : g_bad_mux_width
      $fatal(1, "hynoc_egress_pktarb: MUX_INPUT_WIDTH must equal NB_INPUTS*FLIT_WIDTH");
    end
    if ((2 ** LOG2_INPUTS) < NB_INPUTS) begin : g_bad_log2_inputs
      $fatal(1, "hynoc_egress_pktarb: LOG2_INPUTS too small for NB_INPUTS");
    end
    if ((AFULL_MARGIN < 1) || (AFULL_MARGIN > (2 ** LOG2_FIFO_DEPTH) - 1)) begin : g_bad_margin
      $fatal(1, "hynoc_egress_pktarb: AFULL_MARGIN out of range");
    end
  endgenerate

  localparam int FIFO_DEPTH = 2 ** LOG2_FIFO_DEPTH;
  localparam logic [LOG2_FIFO_DEPTH:0] AFULL_LEVEL = (LOG2_FIFO_DEPTH + 1)'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [LOG2_INPUTS:0]     NB_WIDE     = (LOG2_INPUTS + 1)'(NB_INPUTS);
  localparam logic [NB_INPUTS-1:0]     ONE_HOT0    = {{(NB_INPUTS - 1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                   state, state_nxt;
  logic [LOG2_INPUTS-1:0]   sel, sel_nxt, rr_ptr, rr_ptr_nxt, winner, sel_inc;
  logic [LOG2_INPUTS:0]     idx;
  logic [FLIT_WIDTH-1:0]    data_sel;
  logic                     write_sel, stop_write, afull_c, any_req;
  logic                     wen_nxt;
  logic [FLIT_WIDTH-1:0]    wdata_nxt;
  logic [NB_INPUTS-1:0]     grant_nxt, afull_nxt;

  assign wclk       = router_clk;
  assign wsrst      = router_srst;
  assign any_req    = |from_ingress_request;
  assign write_sel  = from_ingress_write[sel];
  assign stop_write = (state == LOCKED) && write_sel && data_sel[FLIT_WIDTH-1];
  assign afull_c    = (wlevel >= AFULL_LEVEL);
  assign sel_inc    = (({1'b0, sel} + (LOG2_INPUTS + 1)'(1)) == NB_WIDE) ? '0 : sel + LOG2_INPUTS'(1);

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NB_INPUTS; i++) begin
      if (sel == LOG2_INPUTS'(i)) data_sel = from_ingress_data[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  // Scan downward so the requester closest to rr_ptr (modulo NB_INPUTS) is the last one assigned.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = NB_INPUTS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (LOG2_INPUTS + 1)'(k);
      if (idx >= NB_WIDE) idx = idx - NB_WIDE;
      if (from_ingress_request[idx[LOG2_INPUTS-1:0]]) winner = idx[LOG2_INPUTS-1:0];
    end
  end

  always_ff @(posedge router_clk) begin
    if (router_srst) begin
      state            <= IDLE;
      sel              <= '0;
      rr_ptr           <= '0;
      wen              <= 1'b0;
      wdata            <= '0;
      to_ingress_grant <= '0;
      to_ingress_afull <= '0;
    end else begin
      state            <= state_nxt;
      sel              <= sel_nxt;
      rr_ptr           <= rr_ptr_nxt;
      wen              <= wen_nxt;
      wdata            <= wdata_nxt;
      to_ingress_grant <= grant_nxt;
      to_ingress_afull <= afull_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = LOCKED;
          sel_nxt   = winner;
        end
      end
      LOCKED: begin
        if (stop_write) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = sel_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The grant is dropped in the same cycle the stop flit is accepted, so afull follows it exactly.
  always_comb begin
    wen_nxt   = 1'b0;
    wdata_nxt = data_sel;
    grant_nxt = '0;
    case (state)
      IDLE: begin
        if (any_req) grant_nxt = ONE_HOT0 << winner;
      end
      LOCKED: begin
        wen_nxt = write_sel;
        if (!stop_write) grant_nxt = ONE_HOT0 << sel;
      end
      default: grant_nxt = '0;
    endcase
    afull_nxt = {NB_INPUTS{afull_c}} & grant_nxt;
  end

`ifdef HYNOC_EGRESS_STATS_EN
  // Counters watch the registered write port so they reflect exactly what reached the FIFO.
  always_ff @(posedge router_clk) begin
    if (router_srst) begin
      stat_flits   <= '0;
      stat_packets <= '0;
    end else if (wen) begin
      stat_flits <= stat_flits + 32'd1;
      if (wdata[FLIT_WIDTH-1]) stat_packets <= stat_packets + 16'd1;
    end
  end
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_hynoc_egress_pktarb.sv
// Self-checking bench for hynoc_egress_pktarb: directed scenarios plus randomized traffic vs. a packet-level model.
// Define HYNOC_EGRESS_STATS_EN for both files to also exercise the statistics counters.
module tb_hynoc_egress_pktarb;

  localparam int NB     = 4;
  localparam int FW     = 33;
  localparam int LFD    = 5;
  localparam int MARGIN = 5;

  logic              router_clk = 1'b0;
  logic              router_srst = 1'b1;
  logic              wclk, wsrst, wen;
  logic [FW-1:0]     wdata;
  logic [LFD:0]      wlevel = '0;
  logic [NB-1:0]     req = '0, wr = '0, grant, afull;
  logic [NB*FW-1:0]  data = '0;
`ifdef HYNOC_EGRESS_STATS_EN
  logic [31:0]       stat_flits;
  logic [15:0]       stat_packets;
  logic [31:0]       exp_flits;
  logic [15:0]       exp_packets;
`endif

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  hynoc_egress_pktarb dut (
    .router_clk           (router_clk),
    .router_srst          (router_srst),
    .wclk                 (wclk),
    .wsrst                (wsrst),
    .wen                  (wen),
    .wdata                (wdata),
    .wlevel               (wlevel),
    .from_ingress_request (req),
    .from_ingress_write   (wr),
    .from_ingress_data    (data),
    .to_ingress_grant     (grant),
    .to_ingress_afull     (afull)
`ifdef HYNOC_EGRESS_STATS_EN
    ,
    .stat_flits           (stat_flits),
    .stat_packets         (stat_packets)
`endif
  );

  always #5 router_clk = ~router_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setFlit(input int i, input logic stop, input logic [31:0] payload);
    data[i*FW +: FW] = {stop, payload};
  endtask

  task automatic applyStimulus(input logic [NB-1:0] r, input logic [NB-1:0] w, input logic [LFD:0] lvl);
    req    = r;
    wr     = w;
    wlevel = lvl;
  endtask

  task automatic applyReset();
    @(negedge router_clk);
    router_srst = 1'b1;
    applyStimulus('0, '0, '0);
    @(negedge router_clk);
    checkOutput("rst_wen", wen, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_afull", afull, 0);
    router_srst = 1'b0;
  endtask

  // Packet-level reference: who owns the output, where the round-robin scan starts next.
  logic           m_locked;
  int             m_owner, m_ptr;
  logic           exp_wen, exp_wdata_known;
  logic [FW-1:0]  exp_wdata;
  logic [NB-1:0]  exp_grant, exp_afull;

  always @(posedge router_clk) begin
    int w;
    logic [FW-1:0] flit;
`ifdef HYNOC_EGRESS_STATS_EN
    if (router_srst) begin
      exp_flits   = '0;
      exp_packets = '0;
    end else if (exp_wen) begin
      exp_flits = exp_flits + 32'd1;
      if (exp_wdata[FW-1]) exp_packets = exp_packets + 16'd1;
    end
`endif
    if (router_srst) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0;
      exp_wen = 1'b0; exp_wdata = '0; exp_wdata_known = 1'b1;
      exp_grant = '0; exp_afull = '0;
    end else begin
      flit = data[m_owner*FW +: FW];
      if (!m_locked) begin
        exp_wen = 1'b0;
        exp_wdata_known = 1'b0;
        w = -1;
        for (int k = 0; k < NB; k++)
          if (w < 0 && req[(m_ptr + k) % NB]) w = (m_ptr + k) % NB;
        if (w >= 0) begin
          m_locked  = 1'b1;
          m_owner   = w;
          exp_grant = NB'(1) << w;
        end else begin
          exp_grant = '0;
        end
      end else begin
        exp_wen = wr[m_owner];
        exp_wdata = flit;
        exp_wdata_known = wr[m_owner];
        if (wr[m_owner] && flit[FW-1]) begin
          m_locked  = 1'b0;
          m_ptr     = (m_owner + 1) % NB;
          exp_grant = '0;
        end else begin
          exp_grant = NB'(1) << m_owner;
        end
      end
      exp_afull = (int'(wlevel) >= (1 << LFD) - MARGIN) ? exp_grant : '0;
    end
  end

  always @(negedge router_clk) begin
    if (check_en) begin
      checkOutput("cyc_wen", wen, exp_wen);
      checkOutput("cyc_grant", grant, exp_grant);
      checkOutput("cyc_afull", afull, exp_afull);
      checkOutput("cyc_wsrst", wsrst, router_srst);
      checkOutput("cyc_wclk", wclk, router_clk);
      if (exp_wdata_known) checkOutput("cyc_wdata", wdata, exp_wdata);
`ifdef HYNOC_EGRESS_STATS_EN
      checkOutput("cyc_stat_flits", stat_flits, exp_flits);
      checkOutput("cyc_stat_packets", stat_packets, exp_packets);
`endif
    end
  end

  initial begin
    @(posedge router_clk);
    #1 check_en = 1'b1;

    // Single 3-flit packet from input 2.
    applyReset();
    applyStimulus(4'b0100, 4'b0000, '0);
    @(negedge router_clk);
    checkOutput("sp_grant", grant, 4'b0100);
    @(negedge router_clk);
    checkOutput("sp_no_write", wen, 0);
    setFlit(2, 1'b0, 32'hA0);
    applyStimulus(4'b0100, 4'b0100, '0);
    @(negedge router_clk);
    checkOutput("sp_wen0", wen, 1);
    checkOutput("sp_data0", wdata, {1'b0, 32'hA0});
    setFlit(2, 1'b0, 32'hA1);
    @(negedge router_clk);
    checkOutput("sp_data1", wdata, {1'b0, 32'hA1});
    setFlit(2, 1'b1, 32'hA2);
    applyStimulus(4'b0000, 4'b0100, '0);
    @(negedge router_clk);
    checkOutput("sp_wen2", wen, 1);
    checkOutput("sp_data2", wdata, {1'b1, 32'hA2});
    checkOutput("sp_grant_clr", grant, 0);
    applyStimulus('0, '0, '0);
    @(negedge router_clk);
    checkOutput("sp_wen_off", wen, 0);
`ifdef HYNOC_EGRESS_STATS_EN
    applyStimulus(4'b0001, 4'b0000, '0);
    @(negedge router_clk);
    setFlit(0, 1'b1, 32'hB0);
    applyStimulus(4'b0000, 4'b0001, '0);
    @(negedge router_clk);
    applyStimulus('0, '0, '0);
    @(negedge router_clk);
    checkOutput("stat_flits_4", stat_flits, 4);
    checkOutput("stat_packets_2", stat_packets, 2);
`endif

    // Round-robin with 1-flit packets and all inputs requesting.
    applyReset();
    applyStimulus(4'b1111, 4'b0000, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge router_clk);
      checkOutput("rr_grant", grant, 64'(1) << (k % 4));
      setFlit(k % 4, 1'b1, 32'(k));
      applyStimulus(4'b1111, NB'(1) << (k % 4), '0);
      @(negedge router_clk);
      checkOutput("rr_gap", grant, 0);
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 4'b0000, '0);
    end

    // Atomicity: request drops mid-packet, another input waits for the stop flit.
    applyStimulus(4'b0010, 4'b0000, '0);
    @(negedge router_clk);
    checkOutput("at_grant", grant, 4'b0010);
    setFlit(1, 1'b0, 32'hC0);
    applyStimulus(4'b1000, 4'b0010, '0);
    @(negedge router_clk);
    checkOutput("at_hold", grant, 4'b0010);
    setFlit(1, 1'b1, 32'hC1);
    @(negedge router_clk);
    checkOutput("at_release", grant, 0);
    applyStimulus(4'b1000, 4'b0000, '0);
    @(negedge router_clk);
    checkOutput("at_next", grant, 4'b1000);
    setFlit(3, 1'b1, 32'hD0);
    applyStimulus(4'b0000, 4'b1000, '0);
    @(negedge router_clk);

    // Almost-full threshold at 27 for depth 32 with margin 5.
    applyStimulus(4'b0001, 4'b0000, 6'd26);
    @(negedge router_clk);
    checkOutput("af_26", afull, 0);
    applyStimulus(4'b0001, 4'b0000, 6'd27);
    @(negedge router_clk);
    checkOutput("af_27", afull, 4'b0001);
    applyStimulus(4'b0001, 4'b1000, 6'd31);
    @(negedge router_clk);
    checkOutput("af_31", afull, 4'b0001);
    checkOutput("ign_locked", wen, 0);
    setFlit(0, 1'b1, 32'hE0);
    applyStimulus(4'b0000, 4'b0001, 6'd0);
    @(negedge router_clk);
    applyStimulus(4'b0000, 4'b1000, 6'd0);
    @(negedge router_clk);
    checkOutput("af_clear", afull, 0);
    @(negedge router_clk);
    checkOutput("ign_idle_wen", wen, 0);
    checkOutput("ign_idle_grant", grant, 0);

    // Reset in the middle of a packet.
    applyStimulus(4'b0100, 4'b0000, '0);
    @(negedge router_clk);
    setFlit(2, 1'b0, 32'hF0);
    applyStimulus(4'b0100, 4'b0100, '0);
    @(negedge router_clk);
    checkOutput("mr_wen_before", wen, 1);
    router_srst = 1'b1;
    @(negedge router_clk);
    checkOutput("mr_wen", wen, 0);
    checkOutput("mr_grant", grant, 0);
    checkOutput("mr_afull", afull, 0);
    checkOutput("mr_wdata", wdata, 0);
    router_srst = 1'b0;
    applyStimulus(4'b1111, 4'b0000, '0);
    @(negedge router_clk);
    checkOutput("mr_ptr_restart", grant, 4'b0001);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge router_clk);
      router_srst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NB; i++) setFlit(i, $urandom_range(0, 3) == 0, $urandom);
      applyStimulus(NB'($urandom), NB'($urandom), 6'($urandom_range(20, 35)));
    end
    @(negedge router_clk);
    router_srst = 1'b0;
    applyStimulus('0, '0, '0);
    repeat (3) @(negedge router_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
